// File: rtl/graph_isa_pkg.sv
// Shared graph-ISA definitions: the upsample engine's FSM encoding,
// its dispatcher opcode and the scale-factor normalisation rule.
package graph_isa_pkg;

  localparam logic [7:0] OPC_UPSAMPLE2D = 8'h1C;

  typedef enum logic [2:0] {
    UP_IDLE,
    UP_READ,
    UP_SRAM_WAIT,
    UP_LATCH,
    UP_WRITE,
    UP_DONE
  } up_state_t;

  // A scale factor of 0 behaves as 1.
  function automatic logic [7:0] up_factor(input logic [7:0] f);
    return (f == 8'd0) ? 8'd1 : f;
  endfunction

endpackage

// File: rtl/upsample2d_engine_if.sv
// Command and SRAM0 port bundle for upsample2d_engine.
// Optional macro UPSAMPLE2D_ZERO_FILL_EN adds cmd_zero_fill.
interface upsample2d_engine_if #(
  parameter int unsigned SRAM0_AW = 16
);
  logic                cmd_valid;
  logic [15:0]         cmd_src_base;
  logic [15:0]         cmd_dst_base;
  logic [15:0]         cmd_C;
  logic [15:0]         cmd_H;
  logic [15:0]         cmd_W;
  logic [7:0]          cmd_fh;
  logic [7:0]          cmd_fw;
`ifdef UPSAMPLE2D_ZERO_FILL_EN
  logic                cmd_zero_fill;
`endif
  logic                sram_rd_en;
  logic [SRAM0_AW-1:0] sram_rd_addr;
  logic [7:0]          sram_rd_data;
  logic                sram_wr_en;
  logic [SRAM0_AW-1:0] sram_wr_addr;
  logic [7:0]          sram_wr_data;
  logic                busy;
  logic                done;

  modport master (
    input  cmd_valid, cmd_src_base, cmd_dst_base, cmd_C, cmd_H, cmd_W,
           cmd_fh, cmd_fw,
`ifdef UPSAMPLE2D_ZERO_FILL_EN
           cmd_zero_fill,
`endif
           sram_rd_data,
    output sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
           busy, done
  );

  modport slave (
    output cmd_valid, cmd_src_base, cmd_dst_base, cmd_C, cmd_H, cmd_W,
           cmd_fh, cmd_fw,
`ifdef UPSAMPLE2D_ZERO_FILL_EN
           cmd_zero_fill,
`endif
           sram_rd_data,
    input  sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
           busy, done
  );

endinterface

// File: rtl/upsample2d_addr_gen.sv
// Combinational source/destination address generation for the upsampler.
// All arithmetic is 16-bit and wraps; the result is cut to SRAM0_AW bits.
module upsample2d_addr_gen #(
  parameter int unsigned SRAM0_AW = 16
) (
  input  logic [15:0]         i_src_base,
  input  logic [15:0]         i_dst_base,
  input  logic [15:0]         i_c,
  input  logic [15:0]         i_h,
  input  logic [15:0]         i_w,
  input  logic [7:0]          i_fy,
  input  logic [7:0]          i_fx,
  input  logic [15:0]         i_in_w,
  input  logic [7:0]          i_fh,
  input  logic [7:0]          i_fw,
  input  logic [15:0]         i_out_w,
  input  logic [15:0]         i_in_cs,
  input  logic [15:0]         i_out_cs,
  output logic [SRAM0_AW-1:0] o_src_addr,
  output logic [SRAM0_AW-1:0] o_dst_addr
);

  logic [15:0] w_row;
  logic [15:0] w_col;
  logic [15:0] w_src;
  logic [15:0] w_dst;

  // Multiply-add chains for the input pixel and its output block position.
  always_comb begin
    w_row = i_h * {8'd0, i_fh} + {8'd0, i_fy};
    w_col = i_w * {8'd0, i_fw} + {8'd0, i_fx};
    w_src = i_src_base + i_c * i_in_cs + i_h * i_in_w + i_w;
    w_dst = i_dst_base + i_c * i_out_cs + w_row * i_out_w + w_col;
  end

  assign o_src_addr = w_src[SRAM0_AW-1:0];
  assign o_dst_addr = w_dst[SRAM0_AW-1:0];

endmodule

// File: rtl/upsample2d_engine.sv
// Nearest-neighbour 2D upsampler over INT8 NCHW tensors in SRAM0.
// Each input pixel is read once and written into an fh x fw output block.
// Optional macro UPSAMPLE2D_ZERO_FILL_EN: MaxUnpool-style scatter where
// only block position (0,0) carries the pixel and the rest are zero.
module upsample2d_engine
  import graph_isa_pkg::*;
#(
  parameter int unsigned SRAM0_AW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  upsample2d_engine_if.master bus
);

  up_state_t r_state;
  up_state_t w_next;

  logic [15:0] r_src, r_dst, r_C, r_H, r_W, r_OW, r_in_cs, r_out_cs;
  logic [7:0]  r_fh, r_fw;
  logic [15:0] r_c, r_h, r_w;
  logic [7:0]  r_fy, r_fx;
  logic [7:0]  r_val;
  logic        r_rd_en, r_wr_en;
  logic [SRAM0_AW-1:0] r_rd_addr, r_wr_addr;
  logic [7:0]  r_wr_data;
`ifdef UPSAMPLE2D_ZERO_FILL_EN
  logic        r_zero_fill;
`endif

  logic [7:0]  w_fh, w_fw, w_wr_val;
  logic [15:0] w_OH, w_OW, w_in_cs, w_out_cs;
  logic        w_cmd_empty, w_fx_last, w_fy_last, w_w_last, w_h_last, w_c_last;
  logic        w_blk_last, w_pix_last;
  logic [SRAM0_AW-1:0] w_src_addr, w_dst_addr;

  upsample2d_addr_gen #(.SRAM0_AW(SRAM0_AW)) u_addr_gen (
    .i_src_base (r_src),
    .i_dst_base (r_dst),
    .i_c        (r_c),
    .i_h        (r_h),
    .i_w        (r_w),
    .i_fy       (r_fy),
    .i_fx       (r_fx),
    .i_in_w     (r_W),
    .i_fh       (r_fh),
    .i_fw       (r_fw),
    .i_out_w    (r_OW),
    .i_in_cs    (r_in_cs),
    .i_out_cs   (r_out_cs),
    .o_src_addr (w_src_addr),
    .o_dst_addr (w_dst_addr)
  );

  // Command-time dimension precompute and loop-end detection.
  always_comb begin
    w_fh        = up_factor(bus.cmd_fh);
    w_fw        = up_factor(bus.cmd_fw);
    w_OH        = bus.cmd_H * {8'd0, w_fh};
    w_OW        = bus.cmd_W * {8'd0, w_fw};
    w_in_cs     = bus.cmd_H * bus.cmd_W;
    w_out_cs    = w_OH * w_OW;
    w_cmd_empty = (bus.cmd_C == 16'd0) || (bus.cmd_H == 16'd0) || (bus.cmd_W == 16'd0);
    w_fx_last   = (r_fx == r_fw - 8'd1);
    w_fy_last   = (r_fy == r_fh - 8'd1);
    w_w_last    = (r_w == r_W - 16'd1);
    w_h_last    = (r_h == r_H - 16'd1);
    w_c_last    = (r_c == r_C - 16'd1);
    w_blk_last  = w_fx_last && w_fy_last;
    w_pix_last  = w_w_last && w_h_last && w_c_last;
`ifdef UPSAMPLE2D_ZERO_FILL_EN
    w_wr_val    = (r_zero_fill && ((r_fy != 8'd0) || (r_fx != 8'd0))) ? '0 : r_val;
`else
    w_wr_val    = r_val;
`endif
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      UP_IDLE:      if (bus.cmd_valid) w_next = w_cmd_empty ? UP_DONE : UP_READ;
      UP_READ:      w_next = UP_SRAM_WAIT;
      UP_SRAM_WAIT: w_next = UP_LATCH;
      UP_LATCH:     w_next = UP_WRITE;
      UP_WRITE:     if (w_blk_last) w_next = w_pix_last ? UP_DONE : UP_READ;
      UP_DONE:      w_next = UP_IDLE;
      default:      w_next = UP_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= UP_IDLE;
    else        r_state <= w_next;
  end

  // Command latch, loop counters and registered SRAM strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src <= '0; r_dst <= '0; r_C <= '0; r_H <= '0; r_W <= '0;
      r_OW <= '0; r_in_cs <= '0; r_out_cs <= '0; r_fh <= '0; r_fw <= '0;
      r_c <= '0; r_h <= '0; r_w <= '0; r_fy <= '0; r_fx <= '0;
      r_val <= '0; r_rd_en <= 1'b0; r_wr_en <= 1'b0;
      r_rd_addr <= '0; r_wr_addr <= '0; r_wr_data <= '0;
`ifdef UPSAMPLE2D_ZERO_FILL_EN
      r_zero_fill <= 1'b0;
`endif
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      unique case (r_state)
        UP_IDLE: if (bus.cmd_valid) begin
          r_src <= bus.cmd_src_base; r_dst <= bus.cmd_dst_base;
          r_C <= bus.cmd_C; r_H <= bus.cmd_H; r_W <= bus.cmd_W;
          r_fh <= w_fh; r_fw <= w_fw; r_OW <= w_OW;
          r_in_cs <= w_in_cs; r_out_cs <= w_out_cs;
          r_c <= '0; r_h <= '0; r_w <= '0; r_fy <= '0; r_fx <= '0;
`ifdef UPSAMPLE2D_ZERO_FILL_EN
          r_zero_fill <= bus.cmd_zero_fill;
`endif
        end
        UP_READ: begin
          r_rd_en   <= 1'b1;
          r_rd_addr <= w_src_addr;
        end
        UP_LATCH: r_val <= bus.sram_rd_data;
        UP_WRITE: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_dst_addr;
          r_wr_data <= w_wr_val;
          // fx innermost, then fy; a finished block steps w, then h, then c.
          if (!w_fx_last) r_fx <= r_fx + 8'd1;
          else begin
            r_fx <= '0;
            if (!w_fy_last) r_fy <= r_fy + 8'd1;
            else begin
              r_fy <= '0;
              if (!w_w_last) r_w <= r_w + 16'd1;
              else begin
                r_w <= '0;
                if (!w_h_last) r_h <= r_h + 16'd1;
                else begin
                  r_h <= '0;
                  r_c <= r_c + 16'd1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sram_rd_en   = r_rd_en;
  assign bus.sram_rd_addr = r_rd_addr;
  assign bus.sram_wr_en   = r_wr_en;
  assign bus.sram_wr_addr = r_wr_addr;
  assign bus.sram_wr_data = r_wr_data;
  assign bus.busy         = (r_state != UP_IDLE);
  assign bus.done         = (r_state == UP_DONE);

endmodule

// File: tb/tb_upsample2d_engine.sv
// Directed self-checking bench for upsample2d_engine with a byte SRAM model.
// Build with UPSAMPLE2D_ZERO_FILL_EN to also exercise the scatter mode.
module tb_upsample2d_engine;
  import graph_isa_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  upsample2d_engine_if #(.SRAM0_AW(16)) bus();
  upsample2d_engine #(.SRAM0_AW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // SRAM0 model: one-cycle read latency, write on strobe, tb preload port.
  logic [7:0]  mem [0:65535];
  int unsigned n_rd = 0, n_wr = 0, n_both = 0;
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus.sram_rd_en) begin
      bus.sram_rd_data <= mem[bus.sram_rd_addr];
      n_rd <= n_rd + 1;
    end
    if (bus.sram_wr_en) begin
      mem[bus.sram_wr_addr] <= bus.sram_wr_data;
      n_wr <= n_wr + 1;
    end
    if (bus.sram_rd_en && bus.sram_wr_en) n_both <= n_both + 1;
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic fill(input logic [15:0] a, input int unsigned n, input logic [7:0] d);
    for (int unsigned i = 0; i < n; i++) preload(a + 16'(i), d);
  endtask

  task automatic issue(input logic [15:0] src, input logic [15:0] dst,
                       input logic [15:0] c, input logic [15:0] h, input logic [15:0] w,
                       input logic [7:0] fh, input logic [7:0] fw, input logic zf);
    @(negedge clk);
    bus.cmd_src_base = src; bus.cmd_dst_base = dst;
    bus.cmd_C = c; bus.cmd_H = h; bus.cmd_W = w;
    bus.cmd_fh = fh; bus.cmd_fw = fw;
`ifdef UPSAMPLE2D_ZERO_FILL_EN
    bus.cmd_zero_fill = zf;
`else
    if (zf) $display("[TB] zero-fill request ignored in this build");
`endif
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Runs one command; cyc counts busy cycles up to and including done.
  task automatic run_cmd(input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] c, input logic [15:0] h, input logic [15:0] w,
                         input logic [7:0] fh, input logic [7:0] fw, input logic zf,
                         output int unsigned cyc, output logic wr_at_done, output logic timeout);
    issue(src, dst, c, h, w, fh, fw, zf);
    cyc = 1;
    while (!bus.done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    timeout    = !bus.done;
    wr_at_done = bus.sram_wr_en;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if ({bus.busy, bus.done, bus.sram_rd_en, bus.sram_wr_en} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000",
                         {bus.busy, bus.done, bus.sram_rd_en, bus.sram_wr_en});
    end
    n_tests++;
    if ({bus.sram_rd_addr, bus.sram_wr_addr, bus.sram_wr_data} !== 40'd0) begin
      n_fail++; $display("FAIL reset_bus: got %h expected 0",
                         {bus.sram_rd_addr, bus.sram_wr_addr, bus.sram_wr_data});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic_2x2();
    logic [7:0] exp [16] = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4};
    int unsigned cyc, rd0, wr0;
    logic wad, to;
    for (int unsigned i = 0; i < 4; i++) preload(16'h0100 + 16'(i), 8'(i + 1));
    fill(16'h0200, 17, 8'hEE);
    rd0 = n_rd; wr0 = n_wr;
    run_cmd(16'h0100, 16'h0200, 16'd1, 16'd2, 16'd2, 8'd2, 8'd2, 1'b0, cyc, wad, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: done never seen, got 0 expected 1"); end
    n_tests++;
    if (cyc !== 29) begin n_fail++; $display("FAIL basic_cycles: got %0d expected 29", cyc); end
    n_tests++;
    if (wad !== 1'b1) begin n_fail++; $display("FAIL basic_wr_with_done: got %b expected 1", wad); end
    n_tests++;
    if (n_wr - wr0 !== 16) begin n_fail++; $display("FAIL basic_writes: got %0d expected 16", n_wr - wr0); end
    n_tests++;
    if (n_rd - rd0 !== 4) begin n_fail++; $display("FAIL basic_reads: got %0d expected 4", n_rd - rd0); end
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got %b expected 0", bus.busy); end
    for (int unsigned i = 0; i < 16; i++) begin
      n_tests++;
      if (mem[16'h0200 + 16'(i)] !== exp[i]) begin
        n_fail++; $display("FAIL basic_dst[%0d]: got %h expected %h", i, mem[16'h0200 + 16'(i)], exp[i]);
      end
    end
    n_tests++;
    if (mem[16'h0210] !== 8'hEE) begin n_fail++; $display("FAIL basic_overrun: got %h expected ee", mem[16'h0210]); end
  endtask

  task automatic test_channels_fw3();
    logic [7:0] src [6] = '{8'h80, 8'h00, 8'h7F, 8'h05, 8'h06, 8'h07};
    int unsigned cyc, wr0;
    logic wad, to;
    for (int unsigned i = 0; i < 6; i++) preload(16'h0300 + 16'(i), src[i]);
    wr0 = n_wr;
    run_cmd(16'h0300, 16'h0400, 16'd2, 16'd1, 16'd3, 8'd1, 8'd3, 1'b0, cyc, wad, to);
    n_tests++;
    if (to || cyc !== 37) begin n_fail++; $display("FAIL chan_cycles: got %0d expected 37", cyc); end
    n_tests++;
    if (n_wr - wr0 !== 18) begin n_fail++; $display("FAIL chan_writes: got %0d expected 18", n_wr - wr0); end
    for (int unsigned i = 0; i < 18; i++) begin
      n_tests++;
      if (mem[16'h0400 + 16'(i)] !== src[i / 3]) begin
        n_fail++; $display("FAIL chan_dst[%0d]: got %h expected %h", i, mem[16'h0400 + 16'(i)], src[i / 3]);
      end
    end
  endtask

  task automatic test_zero_factor();
    int unsigned cyc, wr0;
    logic wad, to;
    preload(16'h0500, 8'h5A);
    fill(16'h0600, 2, 8'hEE);
    wr0 = n_wr;
    run_cmd(16'h0500, 16'h0600, 16'd1, 16'd1, 16'd1, 8'd0, 8'd0, 1'b0, cyc, wad, to);
    n_tests++;
    if (to || cyc !== 5) begin n_fail++; $display("FAIL zf0_cycles: got %0d expected 5", cyc); end
    n_tests++;
    if (n_wr - wr0 !== 1) begin n_fail++; $display("FAIL zf0_writes: got %0d expected 1", n_wr - wr0); end
    n_tests++;
    if (mem[16'h0600] !== 8'h5A) begin n_fail++; $display("FAIL zf0_data: got %h expected 5a", mem[16'h0600]); end
    n_tests++;
    if (mem[16'h0601] !== 8'hEE) begin n_fail++; $display("FAIL zf0_overrun: got %h expected ee", mem[16'h0601]); end
  endtask

  task automatic test_empty();
    int unsigned cyc, rd0, wr0;
    logic wad, to;
    rd0 = n_rd; wr0 = n_wr;
    run_cmd(16'h0100, 16'h0900, 16'd1, 16'd0, 16'd4, 8'd2, 8'd2, 1'b0, cyc, wad, to);
    n_tests++;
    if (to || cyc !== 1) begin n_fail++; $display("FAIL empty_busy_cycles: got %0d expected 1", cyc); end
    n_tests++;
    if ((n_rd - rd0) + (n_wr - wr0) !== 0) begin
      n_fail++; $display("FAIL empty_accesses: got %0d expected 0", (n_rd - rd0) + (n_wr - wr0));
    end
    n_tests++;
    if (wad !== 1'b0) begin n_fail++; $display("FAIL empty_wr_with_done: got %b expected 0", wad); end
  endtask

  task automatic test_reset_mid_job();
    logic [7:0] exp [16] = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4};
    int unsigned seen, wr0, cyc;
    logic wad, to;
    fill(16'h0700, 16, 8'hEE);
    wr0 = n_wr;
    seen = 0;
    issue(16'h0100, 16'h0700, 16'd1, 16'd2, 16'd2, 8'd2, 8'd2, 1'b0);
    for (int unsigned k = 0; k < 100 && seen < 3; k++) begin
      @(posedge clk); #1;
      if (bus.sram_wr_en) seen++;
    end
    n_tests++;
    if (seen !== 3) begin n_fail++; $display("FAIL rstmid_third_write: got %0d expected 3", seen); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.sram_rd_en, bus.sram_wr_en, bus.sram_rd_addr, bus.sram_wr_addr,
         bus.sram_wr_data} !== 44'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h expected 0", {bus.busy, bus.done, bus.sram_rd_en,
        bus.sram_wr_en, bus.sram_rd_addr, bus.sram_wr_addr, bus.sram_wr_data});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_tests++;
    if (n_wr - wr0 !== 2) begin n_fail++; $display("FAIL rstmid_writes: got %0d expected 2", n_wr - wr0); end
    n_tests++;
    if ({mem[16'h0700], mem[16'h0701], mem[16'h0704]} !== 24'h0101EE) begin
      n_fail++; $display("FAIL rstmid_partial: got %h expected 0101ee",
                         {mem[16'h0700], mem[16'h0701], mem[16'h0704]});
    end
    run_cmd(16'h0100, 16'h0700, 16'd1, 16'd2, 16'd2, 8'd2, 8'd2, 1'b0, cyc, wad, to);
    n_tests++;
    if (to || cyc !== 29) begin n_fail++; $display("FAIL rstmid_rerun_cycles: got %0d expected 29", cyc); end
    for (int unsigned i = 0; i < 16; i++) begin
      n_tests++;
      if (mem[16'h0700 + 16'(i)] !== exp[i]) begin
        n_fail++; $display("FAIL rstmid_dst[%0d]: got %h expected %h", i, mem[16'h0700 + 16'(i)], exp[i]);
      end
    end
  endtask

`ifdef UPSAMPLE2D_ZERO_FILL_EN
  task automatic test_zero_fill();
    logic [7:0] exp [16] = '{1,0,2,0, 0,0,0,0, 3,0,4,0, 0,0,0,0};
    int unsigned cyc;
    logic wad, to;
    fill(16'h0800, 16, 8'hEE);
    run_cmd(16'h0100, 16'h0800, 16'd1, 16'd2, 16'd2, 8'd2, 8'd2, 1'b1, cyc, wad, to);
    n_tests++;
    if (to || cyc !== 29) begin n_fail++; $display("FAIL zfill_cycles: got %0d expected 29", cyc); end
    for (int unsigned i = 0; i < 16; i++) begin
      n_tests++;
      if (mem[16'h0800 + 16'(i)] !== exp[i]) begin
        n_fail++; $display("FAIL zfill_dst[%0d]: got %h expected %h", i, mem[16'h0800 + 16'(i)], exp[i]);
      end
    end
  endtask
`endif

  task automatic test_no_overlap();
    n_tests++;
    if (n_both !== 0) begin n_fail++; $display("FAIL rd_wr_overlap: got %0d expected 0", n_both); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_src_base = '0; bus.cmd_dst_base = '0;
    bus.cmd_C = '0; bus.cmd_H = '0; bus.cmd_W = '0;
    bus.cmd_fh = '0; bus.cmd_fw = '0;
`ifdef UPSAMPLE2D_ZERO_FILL_EN
    bus.cmd_zero_fill = 1'b0;
`endif
    $display("[TB] upsample2d opcode %02h", OPC_UPSAMPLE2D);
    test_reset();
    test_basic_2x2();
    test_channels_fw3();
    test_zero_factor();
    test_empty();
    test_reset_mid_job();
`ifdef UPSAMPLE2D_ZERO_FILL_EN
    test_zero_fill();
`endif
    test_no_overlap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
